// File: rtl/ifetch_buf.sv
// ifetch_buf: fetch stage owning the PC, one outstanding imem request,
// a prefetch FIFO and the IF/ID register with stall and redirect/flush.
// Ports: clk, rst (async, active-high); redirect, redirect_pc from EX/MEM;
//   id_stall from hazard logic; imem_req/imem_addr/imem_ack/imem_rdata
//   memory handshake; if_id_valid/if_id_instr/if_id_npc IF/ID register;
//   fifo_count prefetch occupancy.
// Optional: define IFETCH_PERF_EN to add perf_fetched, perf_dropped and
//   perf_stall saturating 32-bit event counters.
module ifetch_buf #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 32,
    parameter int                DEPTH   = 4,
    parameter int                PC_INCR = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    input  logic                    id_stall,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_ack,
    input  logic [DATA_W-1:0]       imem_rdata,
    output logic                    if_id_valid,
    output logic [DATA_W-1:0]       if_id_instr,
    output logic [ADDR_W-1:0]       if_id_npc,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_dropped,
    output logic [31:0]             perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] npc_mem   [DEPTH];
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] npc_q;

    logic              push;
    logic              pop;
    logic              issue_ok;
    logic [ADDR_W-1:0] nxt_addr;

    assign nxt_addr = addr_q + ADDR_W'(PC_INCR);
    assign push     = (state_q == S_WAIT) && imem_ack && !redirect;
    assign pop      = !id_stall && !redirect && (count_q != '0);
    assign count_d  = count_q + CW'(push) - CW'(pop);
    // Occupancy after this edge must leave room for the data of a
    // request issued now, since acks cannot be back-pressured.
    assign issue_ok = count_d < CW'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end else if (issue_ok) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                        if (imem_ack) begin
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        pc_q <= nxt_addr;
                        if (issue_ok) begin
                            addr_q <= nxt_addr;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= imem_rdata;
            npc_mem[wr_q]   <= nxt_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (redirect) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // No bypass: a freshly pushed entry reaches IF/ID one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            npc_q   <= '0;
        end else if (redirect) begin
            valid_q <= 1'b0;
        end else if (!id_stall) begin
            valid_q <= pop;
            if (pop) begin
                instr_q <= instr_mem[rd_q];
                npc_q   <= npc_mem[rd_q];
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_npc   = npc_q;
    assign fifo_count  = count_q;

`ifdef IFETCH_PERF_EN
    logic          drop_ack;
    logic [CW-1:0] flushed;
    logic [31:0]   fetched_q;
    logic [31:0]   dropped_q;
    logic [31:0]   stall_q;

    assign drop_ack = imem_ack &&
                      (((state_q == S_WAIT) && redirect) ||
                       (state_q == S_DROP));
    assign flushed  = redirect ? count_q : '0;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= sat_add(fetched_q, 32'(push));
            dropped_q <= sat_add(dropped_q,
                                 32'(drop_ack) + 32'(flushed));
            stall_q   <= sat_add(stall_q,
                                 32'(id_stall && (count_q != '0)));
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: a queue-based fetch-stream model
// plus directed scenarios and a randomized stall/redirect/wait-state run.
module tb_ifetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic [2:0]  fifo_count;

    logic        w_req;
    logic [3:0]  w_addr;
    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [3:0]  w_npc;
    logic [2:0]  w_count;

`ifdef IFETCH_PERF_EN
    logic [31:0] p_f, p_d, p_s, wp_f, wp_d, wp_s;
`endif

    always #5 clk = ~clk;

    ifetch_buf #(.DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redir),
        .redirect_pc (rpc),
        .id_stall    (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_npc   (if_id_npc),
        .fifo_count  (fifo_count)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(p_f),
        .perf_dropped(p_d),
        .perf_stall  (p_s)
`endif
    );

    ifetch_buf #(.ADDR_W(4), .RESET_PC(4'hE)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .redirect    (1'b0),
        .redirect_pc (4'h0),
        .id_stall    (1'b0),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .if_id_valid (w_valid),
        .if_id_instr (w_instr),
        .if_id_npc   (w_npc),
        .fifo_count  (w_count)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(wp_f),
        .perf_dropped(wp_d),
        .perf_stall  (wp_s)
`endif
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    bit          pend;
    bit          drop;
    logic [31:0] pend_addr;
    int          wcnt;
    int          wait_cur;
    bit          wait_rand;
    int          wait_fix;
    int          wait_max;
    logic [31:0] exp_fetch;

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic cycle();
        bit          ack_now;
        bit          push;
        bit          pop;
        logic        s_valid;
        logic [31:0] s_instr;
        logic [31:0] s_npc;
        logic [31:0] h;
        logic [31:0] h_npc;
        if (pend) begin
            n_chk++;
            if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
                n_fail++;
                $display("FAIL addr_stable: req=%b addr=%h, want req=1 addr=%h",
                         imem_req, imem_addr, pend_addr);
            end
        end else if (imem_req === 1'b1) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            wcnt      = 0;
            wait_cur  = wait_rand ? int'($urandom_range(0, wait_max)) : wait_fix;
        end
        ack_now = 1'b0;
        if (pend) begin
            if (wcnt == wait_cur) ack_now = 1'b1;
            else wcnt++;
        end
        imem_ack   = ack_now;
        imem_rdata = ack_now ? f(pend_addr) : $urandom;
        w_ack      = w_req;
        w_rdata    = f({28'h0, w_addr});
        push = ack_now && !redir && !drop;
        pop  = !stall && !redir && (q.size() > 0);
        if (push) begin
            n_chk++;
            if (pend_addr !== exp_fetch) begin
                n_fail++;
                $display("FAIL fetch_order: addr=%h, want %h", pend_addr, exp_fetch);
            end
        end
        s_valid = if_id_valid;
        s_instr = if_id_instr;
        s_npc   = if_id_npc;
        @(posedge clk);
        #1;
        n_chk++;
        if (redir) begin
            q.delete();
            if (if_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_flush: valid=%b, want 0", if_id_valid);
            end
        end else if (stall) begin
            if (if_id_valid !== s_valid || if_id_instr !== s_instr ||
                if_id_npc !== s_npc) begin
                n_fail++;
                $display("FAIL stall_hold: v=%b i=%h n=%h, want v=%b i=%h n=%h",
                         if_id_valid, if_id_instr, if_id_npc,
                         s_valid, s_instr, s_npc);
            end
        end else if (pop) begin
            h     = q.pop_front();
            h_npc = h + 32'd1;
            if (if_id_valid !== 1'b1 || if_id_npc !== h_npc ||
                if_id_instr !== f(h)) begin
                n_fail++;
                $display("FAIL ifid_load: v=%b i=%h n=%h, want v=1 i=%h n=%h",
                         if_id_valid, if_id_instr, if_id_npc, f(h), h_npc);
            end
        end else begin
            if (if_id_valid !== 1'b0 || if_id_instr !== s_instr ||
                if_id_npc !== s_npc) begin
                n_fail++;
                $display("FAIL ifid_bubble: v=%b i=%h n=%h, want v=0 i=%h n=%h",
                         if_id_valid, if_id_instr, if_id_npc, s_instr, s_npc);
            end
        end
        if (push) q.push_back(pend_addr);
        n_chk++;
        if (fifo_count !== 3'(q.size()) || fifo_count > 3'(DEPTH)) begin
            n_fail++;
            $display("FAIL fifo_count: got %0d, want %0d", fifo_count, q.size());
        end
        if (redir) exp_fetch = rpc;
        else if (push) exp_fetch = pend_addr + 32'd1;
        if (ack_now) begin
            pend = 1'b0;
            drop = 1'b0;
        end else if (pend && redir) begin
            drop = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        w_ack    = 1'b0;
        redir    = 1'b0;
        stall    = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 ||
            if_id_instr !== 32'h0 || if_id_npc !== 32'h0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b addr=%h v=%b i=%h n=%h cnt=%0d, want all 0",
                     imem_req, imem_addr, if_id_valid, if_id_instr, if_id_npc, fifo_count);
        end
        n_chk++;
        if (w_req !== 1'b0 || w_addr !== 4'hE || w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap: req=%b addr=%h v=%b, want req=0 addr=e v=0",
                     w_req, w_addr, w_valid);
        end
        q.delete();
        pend      = 1'b0;
        drop      = 1'b0;
        exp_fetch = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wait_rand = 1'b0;
        wait_fix  = 0;
        do_reset();
    endtask

    task automatic test_zero_wait();
        wait_rand = 1'b0;
        wait_fix  = 0;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle();
            n_chk++;
            if (k >= 3) begin
                if (if_id_valid !== 1'b1 || if_id_npc !== 32'(k - 2)) begin
                    n_fail++;
                    $display("FAIL zero_wait edge %0d: v=%b n=%h, want v=1 n=%h",
                             k, if_id_valid, if_id_npc, 32'(k - 2));
                end
            end else if (if_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_wait edge %0d: v=%b, want 0", k, if_id_valid);
            end
        end
    endtask

    task automatic test_wait_states();
        int first;
        int pulses;
        wait_rand = 1'b0;
        wait_fix  = 3;
        do_reset();
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 44; k++) begin
            cycle();
            if (if_id_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
                n_chk++;
                if ((k - first) % 4 != 0) begin
                    n_fail++;
                    $display("FAIL wait_spacing: valid at edge %0d, first %0d", k, first);
                end
            end
        end
        n_chk++;
        if (first != 6 || pulses != 10) begin
            n_fail++;
            $display("FAIL wait_pulses: first=%0d count=%0d, want first=6 count=10",
                     first, pulses);
        end
    endtask

    task automatic test_stall_fill();
        int maxc;
        wait_rand = 1'b0;
        wait_fix  = 0;
        do_reset();
        repeat (6) cycle();
        stall = 1'b1;
        maxc  = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            if (fifo_count == 3'(DEPTH)) begin
                n_chk++;
                if (imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_no_req: req=%b, want 0", imem_req);
                end
            end
        end
        n_chk++;
        if (maxc != DEPTH) begin
            n_fail++;
            $display("FAIL stall_fill: max count %0d, want %0d", maxc, DEPTH);
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_chk++;
            if (if_id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL no_bubble: slot %0d valid=%b, want 1", k, if_id_valid);
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        bit got;
        wait_rand = 1'b0;
        wait_fix  = 2;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h5 && !pend) found = 1'b1;
            else cycle();
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_addr5: request to 5 not seen, want seen");
        end
        redir = 1'b1;
        rpc   = 32'h40;
        cycle();
        redir = 1'b0;
        n_chk++;
        if (if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_valid: valid=%b, want 0", if_id_valid);
        end
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (imem_req === 1'b1 && !pend) got = 1'b1;
        end
        n_chk++;
        if (!got || imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL redir_target: seen=%b addr=%h, want seen=1 addr=40",
                     got, imem_addr);
        end
        repeat (12) cycle();
    endtask

    task automatic test_redirect_stall();
        bit seen;
        wait_rand = 1'b0;
        wait_fix  = 0;
        do_reset();
        repeat (5) cycle();
        stall = 1'b1;
        repeat (2) cycle();
        redir = 1'b1;
        rpc   = 32'h100;
        cycle();
        redir = 1'b0;
        n_chk++;
        if (if_id_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL redir_stall: valid=%b cnt=%0d, want valid=0 cnt=0",
                     if_id_valid, fifo_count);
        end
        stall = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            if (if_id_valid === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (!seen || if_id_npc !== 32'h101) begin
            n_fail++;
            $display("FAIL redir_stall_next: seen=%b npc=%h, want seen=1 npc=101",
                     seen, if_id_npc);
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  addrs [3];
        logic [3:0]  npcs  [2];
        logic [31:0] ins   [2];
        int          na;
        int          nv;
        wait_rand = 1'b0;
        wait_fix  = 0;
        do_reset();
        na = 0;
        nv = 0;
        repeat (8) begin
            cycle();
            if (w_req === 1'b1 && na < 3) begin
                addrs[na] = w_addr;
                na++;
            end
            if (w_valid === 1'b1 && nv < 2) begin
                npcs[nv] = w_npc;
                ins[nv]  = w_instr;
                nv++;
            end
        end
        n_chk++;
        if (na != 3 || addrs[0] !== 4'hE || addrs[1] !== 4'hF || addrs[2] !== 4'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: n=%0d %h %h %h, want e f 0",
                     na, addrs[0], addrs[1], addrs[2]);
        end
        n_chk++;
        if (nv != 2 || npcs[0] !== 4'hF || npcs[1] !== 4'h0 ||
            ins[1] !== f(32'hF)) begin
            n_fail++;
            $display("FAIL wrap_npc: n=%0d npc %h %h instr %h, want f 0 instr %h",
                     nv, npcs[0], npcs[1], ins[1], f(32'hF));
        end
    endtask

    task automatic test_reset_mid();
        bit busy;
        wait_rand = 1'b1;
        wait_max  = 3;
        do_reset();
        busy = 1'b0;
        for (int k = 0; k < 30 && !busy; k++) begin
            cycle();
            if (pend && imem_addr !== 32'h0) busy = 1'b1;
        end
        n_chk++;
        if (!busy) begin
            n_fail++;
            $display("FAIL mid_busy: no pending request, want one");
        end
        do_reset();
        repeat (20) cycle();
    endtask

    task automatic test_random();
        wait_rand = 1'b1;
        wait_max  = 3;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 29) == 0);
            rpc   = $urandom;
            cycle();
        end
        stall = 1'b0;
        redir = 1'b0;
        repeat (10) cycle();
    endtask

    initial begin
        #2;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_buf.md
Name: ifetch_buf

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Owns the PC and issues one outstanding request at a time to a handshaked instruction memory.
- Buffers returned instructions in a prefetch FIFO and drives the IF/ID pipeline register with a valid bit.
- Adds stall from hazard logic, redirect/flush from EX/MEM, and wait-state tolerance. The previous stage had none of these.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, PC and address width in bits.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- PC_INCR, 1, PC step per instruction (1 = word-addressed memory).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- redirect  in  1  EX_MEM_PCSrc equivalent: take redirect_pc.
- redirect_pc  in  ADDR_W  target PC for a redirect.
- id_stall  in  1  hold the IF/ID register contents.
- imem_req  out  1  memory request valid.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  memory response valid; imem_rdata is valid this cycle.
- imem_rdata  in  DATA_W  instruction returned.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  DATA_W  IF/ID instruction.
- if_id_npc  out  ADDR_W  IF/ID next-PC (fetch address + PC_INCR).
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC; FSM = IDLE.
  - FIFO empty; fifo_count = 0.
  - imem_req = 0; imem_addr = RESET_PC.
  - if_id_valid = 0; if_id_instr = 0; if_id_npc = 0.
- FSM states: IDLE, WAIT, WAIT_DROP.
- IDLE:
  - Issue condition: fifo_count < DEPTH, or a FIFO pop happens this cycle.
  - If the issue condition holds and no redirect: imem_req = 1, imem_addr = PC, go to WAIT. Request is registered and visible the next cycle.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On ack: push {imem_rdata, imem_addr + PC_INCR}; PC += PC_INCR; drop imem_req.
  - From WAIT, the next request may issue back-to-back in the cycle after ack, subject to the issue condition.
- WAIT_DROP:
  - Entered when a redirect arrives while in WAIT without ack.
  - Request stays asserted until ack. The acked data is discarded (no push). Then go to IDLE.
- Redirect (highest priority):
  - PC = redirect_pc; FIFO cleared; if_id_valid = 0 next edge, even if id_stall = 1.
  - A same-cycle ack in WAIT is discarded, and the FSM goes to IDLE.
  - Redirect in WAIT_DROP: update PC only.
- IF/ID update:
  - When !id_stall and !redirect: if the FIFO is non-empty, load the head and pop, setting if_id_valid = 1; else if_id_valid = 0.
  - Contents retain their old values when not valid.
- Stall: id_stall = 1 freezes all IF/ID outputs; the FIFO keeps filling until full.
- Full/empty:
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Push and pop when empty: the pushed entry is not bypassed, so it appears in IF/ID one cycle later.
  - Minimum latency from request-valid to if_id_valid, ack in the same cycle, FIFO empty, no stall: 2 cycles (push edge, then IF/ID edge).
- Arithmetic:
  - PC and npc wrap modulo 2^ADDR_W, with no overflow flag.
  - FIFO pointers wrap modulo DEPTH.
- Reset mid-request abandons the transaction; memory must tolerate imem_req falling without ack.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (pushes), perf_dropped[31:0] (discarded acks plus FIFO entries flushed by redirect) and perf_stall[31:0] (cycles with id_stall = 1 and FIFO non-empty).
  - All three counters are zero on reset and saturate at 2^32-1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Zero-wait stream: ack in every request cycle, no stall, RESET_PC = 0.
  - if_id_npc sequence is 1, 2, 3, ... with if_id_valid = 1 continuously from the 3rd edge after reset release.
- Wait states: ack after 3 cycles each.
  - imem_addr is stable during each wait; if_id_valid pulses once per 4 cycles; instructions arrive in order.
- Stall fill: id_stall = 1 for 10 cycles, DEPTH = 4.
  - fifo_count reaches 4 and imem_req stays 0 while full; IF/ID is unchanged.
  - After release, 4 consecutive valid instructions appear with no bubble.
- Redirect during WAIT: redirect_pc = 0x40 while the request to 0x5 is pending; ack 2 cycles later.
  - The 0x5 data is never in IF/ID; the next imem_addr is 0x40; if_id_valid = 0 the edge after redirect.
- Redirect with stall: id_stall = 1 and redirect = 1 in the same cycle.
  - if_id_valid = 0 next edge; fifo_count = 0.
- Wrap: ADDR_W = 4, RESET_PC = 0xE.
  - Fetch addresses are 0xE, 0xF, 0x0; if_id_npc for the 0xF fetch is 0x0.
